decim_mac_ctrl: RTL and testbench
=================================

# decim_mac_ctrl

Sequencer for a time-multiplexed, single-MAC implementation of the decimating FIR. It accepts input samples on a `din_rdy` rising edge and writes them into an external circular sample RAM. Every `DESIM`-th sample, it walks the coefficient ROM and the sample RAM through `NUM_TAPS` multiply-accumulate cycles, then flags the finished output. It sits between the sample source and the shared sample RAM, coefficient ROM and MAC datapath, and replaces the fully parallel FIR in area-constrained builds.

## Interface
Parameters:
- `NUM_TAPS`, 49, number of filter taps (≥2, ≤2^AW).
- `DESIM`, 5, decimation factor (≥1).
- `AW`, 6, sample-RAM address width; RAM depth is 2^AW.
- `CW`, 6, coefficient-ROM address width (2^CW ≥ NUM_TAPS).
- `MAC_LAT`, 2, cycles from address issue to the accumulator holding that product (RAM/ROM read plus multiply pipeline).

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `en` in 1: enables the controller; low means idle and flushed.
- `din_rdy` in 1: input sample strobe; only the rising edge is used.
- `data_in` in 16: input sample, valid during the `din_rdy` rising-edge cycle.
- `wr_en` out 1: sample-RAM write strobe.
- `wr_addr` out AW: sample-RAM write address.
- `wr_data` out 16: sample-RAM write data.
- `rd_addr` out AW: sample-RAM read address.
- `coef_addr` out CW: coefficient-ROM read address.
- `mac_clr` out 1: marks the first product of an output; the accumulator loads instead of adding. Aligned to the address cycle.
- `mac_en` out 1: product valid for accumulation. Aligned to the address cycle; the datapath delays it by `MAC_LAT`.
- `dout_rdy` out 1: one-cycle pulse meaning the accumulator holds a finished output.
- `busy` out 1: a compute is in progress.
- `ovr` out 1: sticky overrun flag.
- `ovr_clr` in 1: clears `ovr`.

## Operation
- Edge detect:
  - `din_rdy_d` registers `din_rdy`; `edge = din_rdy & ~din_rdy_d`.
  - Edges are ignored while `en` = 0.
- Write path, on `edge` with `en` = 1:
  - Next cycle drives `wr_en` = 1, `wr_addr` = `wr_ptr`, `wr_data` = captured `data_in`.
  - `wr_ptr` increments mod 2^AW.
  - `newest` is set to the pre-increment `wr_ptr`.
- Phase counter `phase`, range 0..DESIM-1:
  - Increments on each accepted edge.
  - When an edge arrives with `phase` = DESIM-1, `phase` wraps to 0 and a trigger is generated.
- FSM states: IDLE, WRW, MAC, FLUSH, DONE.
  - IDLE → WRW on a trigger.
  - WRW lasts 1 cycle, while the trigger sample's write occurs. → MAC.
  - MAC runs k = 0..NUM_TAPS-1, one tap per cycle:
    - `coef_addr` = k.
    - `rd_addr` = (`newest` − k) mod 2^AW.
    - `mac_en` = 1.
    - `mac_clr` = 1 only when k = 0.
    - After k = NUM_TAPS-1 → FLUSH.
  - FLUSH lasts MAC_LAT-1 cycles, with `mac_en` = 0. If MAC_LAT = 1, FLUSH is skipped.
  - DONE lasts 1 cycle with `dout_rdy` = 1. → IDLE.
- `busy` = 1 in WRW, MAC, FLUSH and DONE.
- Sample writes continue during compute. Reads never touch a slot written after `newest` within the same compute, because DESIM ≤ 2^AW − NUM_TAPS is a configuration requirement.
- Overrun:
  - A trigger while `busy` = 1 sets `ovr` = 1 and is dropped. Its sample is still written and the phase still wraps.
  - `ovr` stays set until `ovr_clr` or `reset`.
  - If `ovr_clr` and a new overrun coincide, the set wins.
- `en` falling:
  - Next cycle the FSM goes to IDLE and `phase` resets to 0.
  - `wr_en`, `mac_en`, `mac_clr` and `dout_rdy` are forced to 0 from that cycle.
  - `wr_ptr` and `ovr` are held.
- Reset: all registers return to 0, including `wr_ptr`, `phase`, `newest` and `din_rdy_d`.

## Timing
- All outputs are registered.
- Reset values: `wr_en` = 0, `wr_addr` = 0, `wr_data` = 0, `rd_addr` = 0, `coef_addr` = 0, `mac_clr` = 0, `mac_en` = 0, `dout_rdy` = 0, `busy` = 0, `ovr` = 0.
- Let E be the cycle in which `edge` = 1:
  - `wr_en` is high in E+1.
  - For a trigger edge: WRW is E+1; MAC spans E+2 .. E+1+NUM_TAPS; `dout_rdy` is high in E+1+NUM_TAPS+MAC_LAT.
  - With defaults, `dout_rdy` is at E+52.
- `busy` is high from E+1 through the `dout_rdy` cycle inclusive.
- A trigger in the cycle after `dout_rdy` is accepted.
- Minimum input spacing is 2 cycles, as implied by edge detection.
- Reset mid-compute:
  - Outputs are at reset values in the cycle after `reset` is sampled high.
  - No `dout_rdy` is produced for the aborted compute.

## Test plan
- Reset, then 5 edges spaced 4 cycles apart with `data_in` = 1..5:
  - `wr_addr` = 0..4, each with `wr_data` equal to the sample.
  - The trigger comes on the 5th edge.
  - `rd_addr` sequence is 4, 3, 2, 1, 0, 63, …, 20 with `coef_addr` 0..48.
  - `mac_clr` is high only on the first MAC cycle.
  - `dout_rdy` is a single pulse 52 cycles after the 5th edge.
- 64 edges at 12-cycle spacing:
  - `wr_ptr` wraps 63→0.
  - 12 `dout_rdy` pulses occur with no `ovr`.
  - `rd_addr` wraps correctly mod 64.
- 10 edges at 2-cycle spacing: the second trigger falls while busy, so `ovr` = 1, that trigger produces no second `dout_rdy`, and all 10 writes still occur.
- `ovr_clr` pulsed with no overrun in the same cycle → `ovr` = 0 the next cycle; `ovr_clr` coincident with an overrun → `ovr` stays 1.
- `en` dropped at MAC k = 10:
  - The cycle after, `mac_en` = 0 and `busy` = 0, and no `dout_rdy` follows.
  - After re-enable, `phase` restarts at 0, so 5 new edges are needed for the next trigger.
- `reset` asserted at MAC k = 20: all outputs are 0 next cycle, the next write goes to `wr_addr` = 0, and no stale `dout_rdy` appears.

Source files
------------

// File: rtl/decim_mac_ctrl.sv
// Sequencer for a single-MAC decimating FIR: writes incoming samples to a circular
// RAM and, every DESIM-th sample, walks NUM_TAPS coefficient/sample address pairs.
module decim_mac_ctrl #(
   parameter int NUM_TAPS = 49,
   parameter int DESIM    = 5,
   parameter int AW       = 6,
   parameter int CW       = 6,
   parameter int MAC_LAT  = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          din_rdy,
   input  logic [15:0]   data_in,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [15:0]   wr_data,
   output logic [AW-1:0] rd_addr,
   output logic [CW-1:0] coef_addr,
   output logic          mac_clr,
   output logic          mac_en,
   output logic          dout_rdy,
   output logic          busy,
   output logic          ovr,
   input  logic          ovr_clr,
   output logic [2:0]    dbg_state
);

   localparam int PW = (DESIM > 1) ? $clog2(DESIM) : 1;
   localparam int FW = (MAC_LAT > 2) ? $clog2(MAC_LAT) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRW   = 3'd1,
      S_MAC   = 3'd2,
      S_FLUSH = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic          din_rdy_q, din_rdy_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] newest_q, newest_d;
   logic [AW-1:0] base_q, base_d;
   logic [PW-1:0] phase_q, phase_d;
   logic [CW-1:0] tap_q, tap_d;
   logic [FW-1:0] flush_q, flush_d;
   logic          ovr_q, ovr_d;
   logic          wr_en_q, wr_en_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [15:0]   wr_data_q, wr_data_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic [CW-1:0] coef_addr_q, coef_addr_d;
   logic          mac_clr_q, mac_clr_d;
   logic          mac_en_q, mac_en_d;
   logic          dout_rdy_q, dout_rdy_d;
   logic          busy_q, busy_d;

   logic din_edge;
   logic trig;
   logic overrun;

   // Handshake: din_rdy is a strobe with no back-pressure; a sample is taken in the
   // cycle din_rdy rises while en is high. A trigger arriving mid-compute is dropped and flagged on ovr.
   always_comb begin
      din_edge = en & din_rdy & ~din_rdy_q;
      trig     = din_edge && (phase_q == PW'(DESIM - 1));
      overrun  = trig && (state_q != S_IDLE);

      din_rdy_d = din_rdy;
      wr_ptr_d  = wr_ptr_q;
      newest_d  = newest_q;
      phase_d   = phase_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;

      if (din_edge) begin
         wr_en_d   = 1'b1;
         wr_addr_d = wr_ptr_q;
         wr_data_d = data_in;
         wr_ptr_d  = wr_ptr_q + 1'b1;
         newest_d  = wr_ptr_q;
         phase_d   = trig ? '0 : phase_q + 1'b1;
      end
      if (!en) phase_d = '0;

      ovr_d = ovr_q;
      if (ovr_clr) ovr_d = 1'b0;
      if (overrun) ovr_d = 1'b1;

      state_d = state_q;
      tap_d   = tap_q;
      flush_d = flush_q;
      base_d  = base_q;
      case (state_q)
         S_IDLE: if (trig) state_d = S_WRW;
         S_WRW: begin
            // newest still points at the trigger sample; freeze it for the whole walk
            state_d = S_MAC;
            tap_d   = '0;
            base_d  = newest_q;
         end
         S_MAC: begin
            if (tap_q == CW'(NUM_TAPS - 1)) begin
               flush_d = '0;
               state_d = (MAC_LAT > 1) ? S_FLUSH : S_DONE;
            end else begin
               tap_d = tap_q + 1'b1;
            end
         end
         S_FLUSH: begin
            if (flush_q == FW'(MAC_LAT - 2)) state_d = S_DONE;
            else flush_d = flush_q + 1'b1;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (!en) state_d = S_IDLE;

      busy_d      = (state_d != S_IDLE);
      mac_en_d    = (state_d == S_MAC);
      mac_clr_d   = mac_en_d && (tap_d == '0);
      dout_rdy_d  = (state_d == S_DONE);
      coef_addr_d = coef_addr_q;
      rd_addr_d   = rd_addr_q;
      if (mac_en_d) begin
         coef_addr_d = tap_d;
         rd_addr_d   = base_d - AW'(tap_d);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         din_rdy_q   <= 1'b0;
         wr_ptr_q    <= '0;
         newest_q    <= '0;
         base_q      <= '0;
         phase_q     <= '0;
         tap_q       <= '0;
         flush_q     <= '0;
         ovr_q       <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         rd_addr_q   <= '0;
         coef_addr_q <= '0;
         mac_clr_q   <= 1'b0;
         mac_en_q    <= 1'b0;
         dout_rdy_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         din_rdy_q   <= din_rdy_d;
         wr_ptr_q    <= wr_ptr_d;
         newest_q    <= newest_d;
         base_q      <= base_d;
         phase_q     <= phase_d;
         tap_q       <= tap_d;
         flush_q     <= flush_d;
         ovr_q       <= ovr_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         rd_addr_q   <= rd_addr_d;
         coef_addr_q <= coef_addr_d;
         mac_clr_q   <= mac_clr_d;
         mac_en_q    <= mac_en_d;
         dout_rdy_q  <= dout_rdy_d;
         busy_q      <= busy_d;
      end
   end

   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign rd_addr   = rd_addr_q;
   assign coef_addr = coef_addr_q;
   assign mac_clr   = mac_clr_q;
   assign mac_en    = mac_en_q;
   assign dout_rdy  = dout_rdy_q;
   assign busy      = busy_q;
   assign ovr       = ovr_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_decim_mac_ctrl.sv
// Bench for decim_mac_ctrl: a schedule-based model predicts every output each cycle,
// with literal checks on latency, address sequence and pulse counts.
module tb_decim_mac_ctrl;
   localparam int N  = 49;
   localparam int D  = 5;
   localparam int L  = 2;
   localparam int AW = 6;
   localparam int CW = 6;

   logic          clk = 1'b0;
   logic          reset, en, din_rdy, ovr_clr;
   logic [15:0]   data_in;
   logic          wr_en, mac_clr, mac_en, dout_rdy, busy, ovr;
   logic [AW-1:0] wr_addr, rd_addr;
   logic [15:0]   wr_data;
   logic [CW-1:0] coef_addr;
   logic [2:0]    dbg_state;

   always #5 clk = ~clk;

   decim_mac_ctrl #(.NUM_TAPS(N), .DESIM(D), .AW(AW), .CW(CW), .MAC_LAT(L)) dut (
      .clk(clk), .reset(reset), .en(en), .din_rdy(din_rdy), .data_in(data_in),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
      .coef_addr(coef_addr), .mac_clr(mac_clr), .mac_en(mac_en), .dout_rdy(dout_rdy),
      .busy(busy), .ovr(ovr), .ovr_clr(ovr_clr), .dbg_state(dbg_state)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // model: a compute is described only by the cycle of its trigger edge and its base address
   int          m_ptr = 0, m_phase = 0, m_start = 0, m_base = 0, m_wa = 0, m_k = 0;
   bit          m_active = 0, m_ovr = 0, m_prev_din = 0, m_rst = 0, m_wr = 0;
   bit          m_edge, m_trig, m_bprev, m_mac, m_oset;
   logic [15:0] exp_q[$];
   logic [15:0] m_d;

   int n_dout = 0, n_wr = 0, dout_cyc = 0, first_rd = -1, last_rd = -1, last_wa = -1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit model_busy(input int c);
      return m_active && (c >= m_start + 1) && (c <= m_start + 1 + N + L);
   endfunction

   always @(negedge clk) begin
      cyc++;
      m_wr  = 0;
      m_rst = 0;
      m_oset = 0;
      if (reset) begin
         m_ptr = 0; m_phase = 0; m_active = 0; m_ovr = 0; m_prev_din = 0; m_rst = 1;
         exp_q.delete();
      end else begin
         m_edge     = en && din_rdy && !m_prev_din;
         m_prev_din = din_rdy;
         m_bprev    = model_busy(cyc - 1);
         if (!en) begin
            m_phase  = 0;
            m_active = 0;
         end
         if (m_edge) begin
            m_wr = 1;
            m_wa = m_ptr;
            exp_q.push_back(data_in);
            m_trig  = (m_phase == D - 1);
            m_phase = m_trig ? 0 : m_phase + 1;
            if (m_trig) begin
               if (m_bprev) m_oset = 1;
               else begin
                  m_active = 1;
                  m_start  = cyc - 1;
                  m_base   = m_ptr;
               end
            end
            m_ptr = (m_ptr + 1) % 64;
         end
         if (ovr_clr) m_ovr = 0;
         if (m_oset) m_ovr = 1;
      end

      if (m_rst) begin
         chk("rst_wr_addr", 32'(wr_addr), 0);
         chk("rst_wr_data", 32'(wr_data), 0);
         chk("rst_rd_addr", 32'(rd_addr), 0);
         chk("rst_coef_addr", 32'(coef_addr), 0);
      end
      m_k   = cyc - m_start - 2;
      m_mac = m_active && (m_k >= 0) && (m_k < N);
      chk("busy", 32'(busy), 32'(model_busy(cyc)));
      chk("mac_en", 32'(mac_en), 32'(m_mac));
      chk("mac_clr", 32'(mac_clr), 32'(m_mac && m_k == 0));
      chk("dout_rdy", 32'(dout_rdy), 32'(m_active && cyc == m_start + 1 + N + L));
      chk("wr_en", 32'(wr_en), 32'(m_wr));
      chk("ovr", 32'(ovr), 32'(m_ovr));
      if (m_wr) begin
         chk("wr_addr", 32'(wr_addr), 32'(m_wa));
         m_d = exp_q.pop_front();
         chk("wr_data", 32'(wr_data), 32'(m_d));
      end
      if (m_mac) begin
         chk("rd_addr", 32'(rd_addr), 32'((m_base - m_k) & 63));
         chk("coef_addr", 32'(coef_addr), 32'(m_k));
      end

      if (dout_rdy === 1'b1) begin n_dout++; dout_cyc = cyc; end
      if (wr_en === 1'b1) begin n_wr++; last_wa = 32'(wr_addr); end
      if (mac_en === 1'b1 && mac_clr === 1'b1) first_rd = 32'(rd_addr);
      if (mac_en === 1'b1 && coef_addr == CW'(N - 1)) last_rd = 32'(rd_addr);
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic edge_pulse(input logic [15:0] d, input int sp);
      din_rdy = 1'b1;
      data_in = d;
      tick(1);
      din_rdy = 1'b0;
      data_in = 16'($urandom);
      tick(sp - 1);
   endtask

   int b_dout, b_wr, e_cyc;

   initial begin
      reset = 1'b1; en = 1'b1; din_rdy = 1'b0; ovr_clr = 1'b0; data_in = '0;
      tick(3);
      reset = 1'b0;
      tick(2);

      // five edges, the fifth triggers
      b_dout = n_dout;
      for (int i = 1; i <= 5; i++) begin
         e_cyc = cyc;
         edge_pulse(16'(i), 4);
      end
      tick(60);
      chk("t1_dout_count", n_dout - b_dout, 1);
      chk("t1_dout_latency", dout_cyc - e_cyc, 52);
      chk("t1_first_rd", first_rd, 4);
      chk("t1_last_rd", last_rd, 20);
      chk("t1_last_wa", last_wa, 4);

      // 64 edges at 12-cycle spacing: pointer wraps, 12 outputs
      b_dout = n_dout;
      for (int i = 0; i < 64; i++) edge_pulse(16'($urandom), 12);
      tick(60);
      chk("t2_dout_count", n_dout - b_dout, 12);
      chk("t2_ovr", 32'(ovr), 0);
      chk("t2_last_wa", last_wa, 4);
      chk("t2_model_ptr", m_ptr, 5);

      // 10 edges at 2-cycle spacing: second trigger overruns
      b_dout = n_dout;
      b_wr   = n_wr;
      for (int i = 0; i < 10; i++) edge_pulse(16'($urandom), 2);
      tick(60);
      chk("t3_dout_count", n_dout - b_dout, 1);
      chk("t3_ovr", 32'(ovr), 1);
      chk("t3_writes", n_wr - b_wr, 10);

      // ovr_clr alone, then coincident with a new overrun
      ovr_clr = 1'b1;
      tick(1);
      ovr_clr = 1'b0;
      chk("t4_ovr_cleared", 32'(ovr), 0);
      edge_pulse(16'($urandom), 2);
      for (int i = 0; i < 4; i++) edge_pulse(16'($urandom), 2);
      din_rdy = 1'b1;
      ovr_clr = 1'b1;
      tick(1);
      din_rdy = 1'b0;
      ovr_clr = 1'b0;
      chk("t4_ovr_set_wins", 32'(ovr), 1);
      tick(60);

      // drop en at MAC k=10
      for (int i = 0; i < 4; i++) edge_pulse(16'($urandom), 4);
      din_rdy = 1'b1;
      data_in = 16'($urandom);
      tick(1);
      din_rdy = 1'b0;
      tick(11);
      en = 1'b0;
      tick(1);
      chk("t5_mac_en_off", 32'(mac_en), 0);
      chk("t5_busy_off", 32'(busy), 0);
      b_dout = n_dout;
      edge_pulse(16'($urandom), 3);
      edge_pulse(16'($urandom), 3);
      tick(60);
      chk("t5_no_dout", n_dout - b_dout, 0);
      en = 1'b1;
      tick(2);
      for (int i = 0; i < 4; i++) edge_pulse(16'($urandom), 4);
      tick(60);
      chk("t5_phase_restart", n_dout - b_dout, 0);
      e_cyc = cyc;
      edge_pulse(16'($urandom), 4);
      tick(60);
      chk("t5_fifth_triggers", n_dout - b_dout, 1);
      chk("t5_latency", dout_cyc - e_cyc, 52);

      // reset at MAC k=20
      for (int i = 0; i < 4; i++) edge_pulse(16'($urandom), 4);
      din_rdy = 1'b1;
      tick(1);
      din_rdy = 1'b0;
      tick(21);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      chk("t6_busy_reset", 32'(busy), 0);
      chk("t6_mac_en_reset", 32'(mac_en), 0);
      b_dout = n_dout;
      tick(60);
      chk("t6_no_stale_dout", n_dout - b_dout, 0);
      edge_pulse(16'h1234, 4);
      chk("t6_wr_addr_zero", last_wa, 0);

      // randomized spacing, data and ovr_clr
      for (int i = 0; i < 60; i++) begin
         ovr_clr = ($urandom_range(0, 7) == 0);
         din_rdy = 1'b1;
         data_in = 16'($urandom);
         tick(1);
         din_rdy = 1'b0;
         ovr_clr = 1'b0;
         tick($urandom_range(1, 13));
      end
      tick(70);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
